clk_div_n: RTL

Runtime-programmable integer clock divider with a 50% duty-cycle output for both even and odd divisors, generalising the fixed divide-by-5 scheme. It sits in the clock-generation area and feeds divided clocks or strobes to downstream logic. Divisor changes are applied only at a period boundary, so the output never produces a runt pulse. An enable input and a period-start tick are provided.

---
 rtl/clk_div_n.sv | 130 +++++++++++++
 1 files changed

// File: rtl/clk_div_n.sv
// clk_div_n -- runtime-programmable integer clock divider, 50% duty cycle.
//
// Divides clk by N (2 .. 2^CNT_W-1). A new divisor is held as pending and
// becomes active only when the period counter wraps, so clk_out never
// produces a runt pulse. While en is low the divider parks at the end of a
// period, so the first enabled cycle starts a clean period with a tick.
//
// Build option:
//   CLKDIV_DUTY50_EN  defined   : a falling-edge register is built, and odd N
//                                 gives an exact N/2 high time.
//                     undefined : clk_out = p; odd N is high (N+1)/2 cycles.
//
// Parameters:
//   CNT_W      divisor / counter width
//   DIV_RESET  divisor active after reset (>= 2)
//
// Ports:
//   clk       input clock
//   rst       synchronous active-high reset
//   en        run enable
//   div_in    requested divisor
//   div_load  one-cycle request to load div_in
//   div_ack   pulse when a loaded divisor becomes active
//   div_err   pulse when a divisor of 0 or 1 is requested
//   div_cur   currently active divisor
//   clk_out   divided clock
//   tick      pulse on the first clk cycle of each output period

module clk_div_n #(
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned DIV_RESET = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_load,
   output logic             div_ack,
   output logic             div_err,
   output logic [CNT_W-1:0] div_cur,
   output logic             clk_out,
   output logic             tick
);

   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
   localparam logic [CNT_W:0]   ONE_W = (CNT_W + 1)'(1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] pend;
   logic             pend_vld;
   logic [CNT_W-1:0] div_nxt;
   logic [CNT_W:0]   half;
   logic             p;
   logic             wrap;
   logic             load_ok;
   logic             load_bad;
   logic             apply;
   logic             err_hold;

   always_comb begin
      wrap     = (cnt == (div_cur - ONE));
      cnt_next = wrap ? '0 : (cnt + ONE);
      // ceil(N/2), one bit wider so N = 2^CNT_W-1 cannot overflow
      half     = ({1'b0, div_cur} + ONE_W) >> 1;
      load_ok  = div_load && (div_in >= TWO);
      load_bad = div_load && (div_in < TWO);
      // While disabled cnt is parked at N-1, so a pending divisor applies
      // on the very next cycle.
      apply    = pend_vld && (wrap || !en);
      div_nxt  = apply ? pend : div_cur;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= CNT_W'(DIV_RESET - 1);
         div_cur  <= CNT_W'(DIV_RESET);
         pend     <= '0;
         pend_vld <= 1'b0;
         p        <= 1'b0;
         tick     <= 1'b0;
         div_ack  <= 1'b0;
         div_err  <= 1'b0;
         err_hold <= 1'b0;
      end else begin
         div_ack <= apply;
         div_cur <= div_nxt;

         // A request arriving on the apply cycle becomes the next pending one.
         if (load_ok) begin
            pend     <= div_in;
            pend_vld <= 1'b1;
         end else if (apply) begin
            pend_vld <= 1'b0;
         end

         // An error coinciding with an ack is deferred one cycle so the two
         // pulses never overlap.
         div_err  <= (load_bad || err_hold) && !apply;
         err_hold <= (load_bad || err_hold) && apply;

         if (en) begin
            cnt  <= cnt_next;
            p    <= ({1'b0, cnt_next} < half);
            tick <= wrap;
         end else begin
            cnt  <= div_nxt - ONE;
            p    <= 1'b0;
            tick <= 1'b0;
         end
      end
   end

`ifdef CLKDIV_DUTY50_EN
   logic n;

   always_ff @(negedge clk) begin
      if (rst) n <= 1'b0;
      else     n <= p;
   end

   // Odd N: the AND with the half-cycle-delayed copy trims half a clk off the
   // high phase. Parity switches only at a wrap, where p was low, so no glitch.
   always_comb clk_out = div_cur[0] ? (p & n) : p;
`else
   always_comb clk_out = p;
`endif

endmodule
